// File: rtl/bridge_pkg.sv
// Shared constants and types for the bridge datapath: payload width,
// request-queue depth and the sender FSM state encoding.
package bridge_pkg;

    localparam int WIDTH    = 8;
    localparam int PEND_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sender_state_t;

    // Bits needed to hold the values 0..maxVal.
    function automatic int cntBits(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/bridge_req_counter.sv
// Saturating up/down counter holding requests that arrived while a word was
// outstanding; a simultaneous inc and dec leaves the count unchanged.
module bridge_req_counter #(
    parameter int MAX = bridge_pkg::PEND_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_nonzero
);
    import bridge_pkg::*;

    localparam int CW = cntBits(MAX);

    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_nonzero;

    assign w_full    = (r_count == CW'(MAX));
    assign w_nonzero = (r_count != '0);

    // Increments beyond MAX are dropped rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && w_nonzero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_full    = w_full;
    assign o_nonzero = w_nonzero;

endmodule

// File: rtl/bridge_sender.sv
// Valid/ready source: each en pulse requests one sequence-numbered word; requests
// arriving while a word is outstanding are queued and issued back-to-back.
module bridge_sender #(
    parameter int WIDTH    = bridge_pkg::WIDTH,
    parameter int PEND_MAX = bridge_pkg::PEND_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);
    import bridge_pkg::*;

    sender_state_t    r_state;
    sender_state_t    w_stateNext;
    logic [WIDTH-1:0] r_seq;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_load;
    logic             w_pendInc;
    logic             w_pendDec;
    logic             w_pendFull;
    logic             w_pendNonzero;

    bridge_req_counter #(
        .MAX(PEND_MAX)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_pendInc),
        .i_dec    (w_pendDec),
        .o_full   (w_pendFull),
        .o_nonzero(w_pendNonzero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Queued requests are served before a fresh en; a fresh en that coincides
    // with serving the queue takes the freed slot, so the count nets to zero.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_pendInc   = 1'b0;
        w_pendDec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en || w_pendNonzero) begin
                    w_load      = 1'b1;
                    w_stateNext = SEND;
                    if (w_pendNonzero) begin
                        w_pendDec = 1'b1;
                        w_pendInc = en;
                    end
                end
            end
            SEND: begin
                if (!ready) begin
                    w_pendInc = en && !w_pendFull;
                end else if (w_pendNonzero) begin
                    w_load    = 1'b1;
                    w_pendDec = 1'b1;
                    w_pendInc = en;
                end else if (en) begin
                    w_load = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // data_out only moves on a load, so it holds through stalls and after the
    // final accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_seq   <= '0;
        end else begin
            if (w_load) begin
                r_data <= r_seq;
                r_seq  <= r_seq + 1'b1;
            end
            r_valid <= (w_stateNext == SEND);
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;

endmodule

// File: tb/tb_bridge_sender.sv
// Self-checking bench for bridge_sender: an owed-word transaction model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bridge_sender;

    localparam int PEND_MAX = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;

    int total = 0;
    int bad   = 0;

    bit         started = 1'b0;
    bit         mValid  = 1'b0;
    logic [7:0] mData   = 8'h00;
    int         nextSeq = 0;
    int         owed    = 0;
    logic [7:0] acceptQ[$];

    bridge_sender #(
        .WIDTH(8),
        .PEND_MAX(PEND_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ready   (ready),
        .data_out(data_out),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic rs);
        @(negedge clk);
        en    = e;
        ready = r;
        rst   = rs;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        acceptQ.delete();
    endtask

    // Model: "owed" counts words still to be delivered (shown + queued), capped
    // at one shown word plus PEND_MAX queued ones.
    always @(posedge clk) begin : model
        int acc;
        int newOwed;
        if (rst) begin
            started = 1'b1;
            mValid  = 1'b0;
            mData   = 8'h00;
            nextSeq = 0;
            owed    = 0;
        end else begin
            acc = (mValid && ready) ? 1 : 0;
            if (acc == 1) acceptQ.push_back(mData);
            newOwed = owed - acc + (en ? 1 : 0);
            if (newOwed > PEND_MAX + 1) newOwed = PEND_MAX + 1;
            if (newOwed > 0 && (acc == 1 || !mValid)) begin
                mData   = nextSeq[7:0];
                nextSeq = (nextSeq + 1) % 256;
            end
            mValid = (newOwed > 0);
            owed   = newOwed;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checkOutput("valid", 32'(valid), 32'(mValid));
            checkOutput("data_out", 32'(data_out), 32'(mData));
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resetValid", 32'(valid), 32'h0);
        checkOutput("resetData", 32'(data_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("postResetIdle", 32'(valid), 32'h0);

        // single request with a stall, then a second request
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("singleValid", 32'(valid), 32'h1);
        checkOutput("singleData", 32'(data_out), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("singleHeld", 32'(data_out), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("singleDrop", 32'(valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("secondData", 32'(data_out), 32'h01);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("secondDrop", 32'(valid), 32'h0);

        // back-to-back
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2bDrop", 32'(valid), 32'h0);
        checkOutput("b2bCount", 32'(acceptQ.size()), 32'd3);
        for (int i = 0; i < acceptQ.size(); i++) checkOutput("b2bWord", 32'(acceptQ[i]), 32'(i));

        // saturation
        resetDut();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("satCount", 32'(acceptQ.size()), 32'd5);
        for (int i = 0; i < acceptQ.size(); i++) checkOutput("satWord", 32'(acceptQ[i]), 32'(i));
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("satNextCount", 32'(acceptQ.size()), 32'd6);
        if (acceptQ.size() == 6) checkOutput("satNextWord", 32'(acceptQ[5]), 32'h05);

        // simultaneous en and ready while valid with nothing queued
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("simFirst", 32'(data_out), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("simValid", 32'(valid), 32'h1);
        checkOutput("simData", 32'(data_out), 32'h01);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("simDrop", 32'(valid), 32'h0);

        // sequence wrap
        resetDut();
        for (int i = 0; i < 257; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrapCount", 32'(acceptQ.size()), 32'd257);
        if (acceptQ.size() == 257) begin
            checkOutput("wrapLast", 32'(acceptQ[255]), 32'hFF);
            checkOutput("wrapZero", 32'(acceptQ[256]), 32'h00);
        end

        // reset while a word and two queued requests are outstanding
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midRstValid", 32'(valid), 32'h0);
        checkOutput("midRstData", 32'(data_out), 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midRstNextValid", 32'(valid), 32'h1);
        checkOutput("midRstNextData", 32'(data_out), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midRstDrained", 32'(valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
